hfrv_bus_tracer: RTL and testbench

- Passive bus-transaction capture stage downstream of the HF-RISC DUT top.
- Taps the CPU memory bus (address, byte write strobes, write data, read data, stall) and reconstructs completed reads and writes, honouring the one-cycle synchronous read latency of boot ROM, RAM and peripherals.
- Filters records by address region and buffers them in a FIFO.
- Presents records on a valid/ready stream consumed by the UVM monitor and scoreboard.

---
 rtl/hfrv_bus_tracer.sv | 194 +++++++++++++++++++
 tb/tb_hfrv_bus_tracer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hfrv_bus_tracer.sv
// hfrv_bus_tracer
//   Passive capture stage for the HF-RISC CPU memory bus. It rebuilds completed
//   reads and writes, filters them by address region and queues them in a
//   first-word fall-through FIFO. The queue is presented on a valid/ready stream.
//   Reads complete one cycle after the request because boot ROM, RAM and the
//   peripherals all have a one-cycle synchronous read latency.
//
// Optional feature: define HFRV_BUS_TRACER_TS_EN to build the timestamp counter
//   and the per-entry timestamp storage. Without it, trace_ts_o is tied to 0.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            tracing enable
//   addr_i              CPU address
//   data_we_i           byte write strobes (0 = read)
//   data_write_i        CPU write data
//   data_read_i         bus read data (after the busmux)
//   stall_i             bus stall
//   trace_valid_o       record available
//   trace_ready_i       consumer accepts the record
//   trace_addr_o        record address
//   trace_data_o        record write data or read data
//   trace_we_o          record strobes (0 = read)
//   trace_ts_o          cycle timestamp of the request
//   overflow_o          sticky flag: at least one record dropped
//   drop_cnt_o          saturating count of dropped records
module hfrv_bus_tracer #(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] REGION_MASK = 16'h4010,
  parameter int          TS_W        = 32,
  parameter int          DROP_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        data_we_i,
  input  logic [31:0]       data_write_i,
  input  logic [31:0]       data_read_i,
  input  logic              stall_i,
  output logic              trace_valid_o,
  input  logic              trace_ready_i,
  output logic [31:0]       trace_addr_o,
  output logic [31:0]       trace_data_o,
  output logic [3:0]        trace_we_o,
  output logic [TS_W-1:0]   trace_ts_o,
  output logic              overflow_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Saturating add of 0..2 drops onto the drop counter.
  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cnt,
                                                     input logic [1:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + (DROP_W+1)'(inc);
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: qualify the bus access presented in the current cycle
  // ---------------------------------------------------------------------------
  logic qual_p0, wr_req_p0, rd_req_p0;

  assign qual_p0   = enable_i & ~stall_i & REGION_MASK[addr_i[31:28]];
  assign wr_req_p0 = qual_p0 & (data_we_i != 4'h0);
  assign rd_req_p0 = qual_p0 & (data_we_i == 4'h0);

`ifdef HFRV_BUS_TRACER_TS_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage p1: pending read waiting for its data one cycle later
  // ---------------------------------------------------------------------------
  logic        vld_p1;
  logic [31:0] pend_addr_p1;
`ifdef HFRV_BUS_TRACER_TS_EN
  logic [TS_W-1:0] pend_ts_p1;
`endif

  // The pending register reloads on every edge, so back-to-back reads each
  // complete exactly one cycle after their request.
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= rd_req_p0;
  end

  always_ff @(posedge clk_i) begin
    if (rd_req_p0) begin
      pend_addr_p1 <= addr_i;
`ifdef HFRV_BUS_TRACER_TS_EN
      pend_ts_p1   <= ts_cnt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO: push arbitration, storage and pointers
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [3:0]    mem_we   [DEPTH];
`ifdef HFRV_BUS_TRACER_TS_EN
  logic [TS_W-1:0] mem_ts [DEPTH];
`endif

  logic [AW-1:0]     wr_ptr, rd_ptr, wr_idx;
  logic [AW:0]       count, free;
  logic              push_rd, push_wr, pop, not_empty;
  logic [1:0]        n_drop;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  assign not_empty = (count != '0);
  assign pop       = not_empty & trace_ready_i;

  // Free slots use occupancy before this cycle's pop. The completing read
  // takes the first free slot, and the write only gets the next one.
  always_comb begin
    free    = DEPTH_C - count;
    push_rd = 1'b0;
    push_wr = 1'b0;
    n_drop  = 2'd0;
    if (vld_p1) begin
      if (free != '0) push_rd = 1'b1;
      else            n_drop  = n_drop + 2'd1;
    end
    if (wr_req_p0) begin
      if (free >= (vld_p1 ? (AW+1)'(2) : (AW+1)'(1))) push_wr = 1'b1;
      else                                            n_drop  = n_drop + 2'd1;
    end
  end

  assign wr_idx = wr_ptr + AW'(push_rd);

  always_ff @(posedge clk_i) begin
    if (push_rd) begin
      mem_addr[wr_ptr] <= pend_addr_p1;
      mem_data[wr_ptr] <= data_read_i;
      mem_we[wr_ptr]   <= 4'h0;
`ifdef HFRV_BUS_TRACER_TS_EN
      mem_ts[wr_ptr]   <= pend_ts_p1;
`endif
    end
    if (push_wr) begin
      mem_addr[wr_idx] <= addr_i;
      mem_data[wr_idx] <= data_write_i;
      mem_we[wr_idx]   <= data_we_i;
`ifdef HFRV_BUS_TRACER_TS_EN
      mem_ts[wr_idx]   <= ts_cnt;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push_rd) + AW'(push_wr);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + (AW+1)'(push_rd) + (AW+1)'(push_wr) - (AW+1)'(pop);
      if (n_drop != 2'd0) overflow <= 1'b1;
      drop_cnt <= sat_add_drop(drop_cnt, n_drop);
    end
  end

  // ---------------------------------------------------------------------------
  // Output stream: head entry, forced to zero while the FIFO is empty
  // ---------------------------------------------------------------------------
  assign trace_valid_o = not_empty;
  assign trace_addr_o  = not_empty ? mem_addr[rd_ptr] : 32'h0;
  assign trace_data_o  = not_empty ? mem_data[rd_ptr] : 32'h0;
  assign trace_we_o    = not_empty ? mem_we[rd_ptr]   : 4'h0;
`ifdef HFRV_BUS_TRACER_TS_EN
  assign trace_ts_o    = not_empty ? mem_ts[rd_ptr]   : '0;
`else
  assign trace_ts_o    = '0;
`endif
  assign overflow_o    = overflow;
  assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_hfrv_bus_tracer.sv
// Directed testbench for hfrv_bus_tracer with the default parameters
// (DEPTH=16, REGION_MASK=16'h4010). Inputs change #1 after the rising edge,
// and outputs are checked at the same point.
module tb_hfrv_bus_tracer;

  localparam int DEPTH  = 16;
  localparam int TS_W   = 32;
  localparam int DROP_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [31:0]       addr = '0;
  logic [3:0]        we = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata = '0;
  logic              stall = 1'b0;
  logic              ready = 1'b0;
  logic              t_valid;
  logic [31:0]       t_addr, t_data;
  logic [3:0]        t_we;
  logic [TS_W-1:0]   t_ts;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int ts_n;

  hfrv_bus_tracer #(.DEPTH(DEPTH), .REGION_MASK(16'h4010), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .addr_i(addr), .data_we_i(we),
    .data_write_i(wdata), .data_read_i(rdata), .stall_i(stall),
    .trace_valid_o(t_valid), .trace_ready_i(ready), .trace_addr_o(t_addr),
    .trace_data_o(t_data), .trace_we_o(t_we), .trace_ts_o(t_ts),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_ts(input int c);
`ifdef HFRV_BUS_TRACER_TS_EN
    return 64'(c);
`else
    return 64'(c) & 64'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic en, input logic st, input logic [31:0] a,
                       input logic [3:0] w, input logic [31:0] wd, input logic [31:0] rd);
    enable = en; stall = st; addr = a; we = w; wdata = wd; rdata = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    idle();
    tick();
    do_reset();

    // Reset state
    chk("rst_valid", 64'(t_valid), 64'h0);
    chk("rst_addr", 64'(t_addr), 64'h0);
    chk("rst_data", 64'(t_data), 64'h0);
    chk("rst_we", 64'(t_we), 64'h0);
    chk("rst_ts", 64'(t_ts), 64'h0);
    chk("rst_ovf", 64'(overflow), 64'h0);
    chk("rst_drop", 64'(drop_cnt), 64'h0);

    // Single write
    tick(); tick();
    ts_n = cyc;
    drive(1'b1, 1'b0, 32'h40000010, 4'hF, 32'hDEADBEEF, 32'h0);
    tick();
    idle();
    chk("wr_valid", 64'(t_valid), 64'h1);
    chk("wr_addr", 64'(t_addr), 64'h40000010);
    chk("wr_data", 64'(t_data), 64'hDEADBEEF);
    chk("wr_we", 64'(t_we), 64'hF);
    chk("wr_ts", 64'(t_ts), exp_ts(ts_n));
    tick();
    chk("wr_hold_addr", 64'(t_addr), 64'h40000010);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("wr_popped", 64'(t_valid), 64'h0);

    // Single read: data in the request cycle is ignored
    ts_n = cyc;
    drive(1'b1, 1'b0, 32'h40000020, 4'h0, 32'h0, 32'hFFFFFFFF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h12345678);
    chk("rd_not_yet", 64'(t_valid), 64'h0);
    tick();
    idle();
    chk("rd_valid", 64'(t_valid), 64'h1);
    chk("rd_addr", 64'(t_addr), 64'h40000020);
    chk("rd_data", 64'(t_data), 64'h12345678);
    chk("rd_we", 64'(t_we), 64'h0);
    chk("rd_ts", 64'(t_ts), exp_ts(ts_n));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rd_popped", 64'(t_valid), 64'h0);

    // Dual push with one free slot: read kept, write dropped
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'b1, 1'b0, 32'h40000100 + 32'(4 * i), 4'hF, 32'(i), 32'h0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h40000000, 4'h0, 32'h0, 32'h55555555);
    tick();
    drive(1'b1, 1'b0, 32'hE0000004, 4'h1, 32'h000000A5, 32'h0BADF00D);
    tick();
    idle();
    chk("dual_drop", 64'(drop_cnt), 64'h1);
    chk("dual_ovf", 64'(overflow), 64'h1);
    ready = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      chk("dual_fill_addr", 64'(t_addr), 64'h40000100 + 64'(4 * i));
      tick();
    end
    chk("dual_rd_valid", 64'(t_valid), 64'h1);
    chk("dual_rd_addr", 64'(t_addr), 64'h40000000);
    chk("dual_rd_data", 64'(t_data), 64'h0BADF00D);
    chk("dual_rd_we", 64'(t_we), 64'h0);
    tick();
    ready = 1'b0;
    chk("dual_empty", 64'(t_valid), 64'h0);

    // Back-to-back reads
    ts_n = cyc;
    drive(1'b1, 1'b0, 32'h40000040, 4'h0, 32'h0, 32'hFFFFFFFF);
    tick();
    drive(1'b1, 1'b0, 32'h40000044, 4'h0, 32'h0, 32'h11111111);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h22222222);
    tick();
    idle();
    ready = 1'b1;
    chk("b2b_addr0", 64'(t_addr), 64'h40000040);
    chk("b2b_data0", 64'(t_data), 64'h11111111);
    chk("b2b_ts0", 64'(t_ts), exp_ts(ts_n));
    tick();
    chk("b2b_addr1", 64'(t_addr), 64'h40000044);
    chk("b2b_data1", 64'(t_data), 64'h22222222);
    chk("b2b_ts1", 64'(t_ts), exp_ts(ts_n + 1));
    tick();
    ready = 1'b0;
    chk("b2b_empty", 64'(t_valid), 64'h0);

    // Overflow: DEPTH+3 writes with the consumer stalled
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(1'b1, 1'b0, 32'h40000000 + 32'(4 * i), 4'hF, 32'(i), 32'h0);
      tick();
    end
    idle();
    chk("ovf_drop", 64'(drop_cnt), 64'h3);
    chk("ovf_flag", 64'(overflow), 64'h1);
    chk("ovf_head", 64'(t_addr), 64'h40000000);
    // A pop while full does not free a slot for a write in the same cycle
    ready = 1'b1;
    drive(1'b1, 1'b0, 32'h4000FFF0, 4'hF, 32'hCAFE, 32'h0);
    tick();
    idle();
    chk("full_pop_drop", 64'(drop_cnt), 64'h4);
    for (int i = 1; i < DEPTH; i++) begin
      chk("ovf_drain_addr", 64'(t_addr), 64'h40000000 + 64'(4 * i));
      chk("ovf_drain_data", 64'(t_data), 64'(i));
      tick();
    end
    ready = 1'b0;
    chk("ovf_empty", 64'(t_valid), 64'h0);

    // Ignored accesses: masked region, stalled, disabled
    drive(1'b1, 1'b0, 32'h00000100, 4'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h40000000, 4'hF, 32'h1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h40000004, 4'hF, 32'h2, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h40000008, 4'h0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0000010C, 4'h0, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    chk("ign_valid", 64'(t_valid), 64'h0);
    chk("ign_drop", 64'(drop_cnt), 64'h4);

    // Reset with a pending read and five queued entries
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'hE0000000 + 32'(4 * i), 4'h3, 32'(i), 32'h0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h40000080, 4'h0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h77777777);
    tick();
    rst = 1'b0;
    cyc = 0;
    chk("rst2_valid", 64'(t_valid), 64'h0);
    chk("rst2_drop", 64'(drop_cnt), 64'h0);
    chk("rst2_ovf", 64'(overflow), 64'h0);
    tick();
    chk("rst2_no_rd", 64'(t_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
